// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, 11-bit ALU control words,
// the decoded-entry struct handed from decode to execute, and the ALU op
// encoding helper.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU control word: bit9 selects the alternate (SUB/SRA) form, bits[2:0] are funct3.
  localparam logic [10:0] ALU_ADD  = 11'h000;
  localparam logic [10:0] ALU_SLL  = 11'h001;
  localparam logic [10:0] ALU_SLT  = 11'h002;
  localparam logic [10:0] ALU_SLTU = 11'h003;
  localparam logic [10:0] ALU_XOR  = 11'h004;
  localparam logic [10:0] ALU_SRL  = 11'h005;
  localparam logic [10:0] ALU_OR   = 11'h006;
  localparam logic [10:0] ALU_AND  = 11'h007;
  localparam logic [10:0] ALU_SUB  = 11'h200;
  localparam logic [10:0] ALU_SRA  = 11'h205;

  typedef struct packed {
    logic [10:0] alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic [31:0] pc;
    logic        reg_write;
    logic        illegal;
  } decoded_t;

  function automatic logic [10:0] alu_op_enc(input logic alt, input logic [2:0] funct3);
    return {1'b0, alt, 6'b0, funct3};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC.
// Ports:
//   instr_i  32-bit instruction word
//   pc_i     instruction address (passed through)
//   dec_o    decoded entry; unsupported encodings come out with illegal=1 and
//            all control fields cleared except the raw register indices and pc
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output decoded_t    dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    dec_o     = '0;
    legal     = 1'b0;
    dec_o.rs1 = instr_i[19:15];
    // rs2 is always the raw field, even for I/U types; use_imm picks the operand.
    dec_o.rs2 = instr_i[24:20];
    dec_o.rd  = instr_i[11:7];
    dec_o.pc  = pc_i;

    case (opcode)
      OPC_OP: begin
        legal = ((funct7 == F7_BASE) && (funct3 != 3'b011)) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_o.alu_op    = alu_op_enc(funct7[5], funct3);
        dec_o.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          3'b011:  legal = 1'b0;
          default: legal = 1'b1;
        endcase
        dec_o.alu_op    = alu_op_enc((funct3 == 3'b101) && instr_i[30], funct3);
        // Shift-right immediates carry only the 5-bit shamt; funct7 is not part of imm.
        dec_o.imm       = (funct3 == 3'b101) ? {27'b0, instr_i[24:20]}
                                             : {{20{instr_i[31]}}, instr_i[31:20]};
        dec_o.use_imm   = 1'b1;
        dec_o.reg_write = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        legal           = 1'b1;
        dec_o.alu_op    = ALU_ADD;
        dec_o.rs1       = 5'd0;
        dec_o.imm       = {instr_i[31:12], 12'b0};
        dec_o.use_imm   = 1'b1;
        dec_o.use_pc    = (opcode == OPC_AUIPC);
        dec_o.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec_o.alu_op    = '0;
      dec_o.imm       = '0;
      dec_o.use_imm   = 1'b0;
      dec_o.use_pc    = 1'b0;
      dec_o.reg_write = 1'b0;
      dec_o.illegal   = 1'b1;
      dec_o.rs1       = instr_i[19:15];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode pipeline stage: decodes one instruction per valid/ready
// handshake into a single output register with backpressure and flush.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop held entry and same-cycle input
//   in_valid/in_ready         fetch-side handshake; in_instr, in_pc payload
//   out_valid/out_ready       execute-side handshake
//   out_alu_op .. out_illegal decoded fields of the held entry
module id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [10:0]     out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_use_pc,
  output logic [XLEN-1:0] out_pc,
  output logic            out_reg_write,
  output logic            out_illegal
);

  decoded_t dec;
  decoded_t data_d, data_q;
  logic     valid_d, valid_q;
  logic     accept;

  instr_decoder u_decoder (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec)
  );

  // No skid buffer: ready only when the register is empty or draining this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      data_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_alu_op    = data_q.alu_op;
  assign out_rs1       = data_q.rs1;
  assign out_rs2       = data_q.rs2;
  assign out_rd        = data_q.rd;
  assign out_imm       = data_q.imm;
  assign out_use_imm   = data_q.use_imm;
  assign out_use_pc    = data_q.use_pc;
  assign out_pc        = data_q.pc;
  assign out_reg_write = data_q.reg_write;
  assign out_illegal   = data_q.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode pipeline stage that produces the ALU control word and operand selects consumed by the core's ALU. It sits between fetch and execute and accepts one 32-bit RV32I instruction per valid/ready handshake. It decodes OP, OP-IMM, LUI and AUIPC, and holds the result in a single pipeline register with backpressure and flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  drops the held entry and any same-cycle input.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction address.
- `out_valid`  out  1  decoded entry is held.
- `out_ready`  in  1  execute consumes the entry.
- `out_alu_op`  out  11  ALU opcode; bit9 = funct7[5], bits[2:0] = funct3, all other bits 0.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices.
- `out_imm`  out  32  sign-extended immediate.
- `out_use_imm`  out  1  operand 2 is `out_imm`, not rs2.
- `out_use_pc`  out  1  operand 1 is `out_pc`, not rs1.
- `out_pc`  out  32  passthrough of `in_pc`.
- `out_reg_write`  out  1  result is written to rd.
- `out_illegal`  out  1  instruction is unsupported.

## Operation
- OP (0110011):
  - funct7 0000000 is legal with any funct3 except 011.
  - funct7 0100000 is legal with funct3 000 or 101 only.
  - alu_op = {1'b0, funct7[5], 6'b0, funct3}; use_imm=0; reg_write=1.
- OP-IMM (0010011):
  - imm = sext(instr[31:20]); use_imm=1; reg_write=1.
  - funct3 001: instr[31:25] must be 0000000.
  - funct3 101: instr[31:25] must be 0000000 or 0100000; bit9 = instr[30]; imm = {27'b0, instr[24:20]}.
  - All other funct3: bit9 = 0.
  - funct3 011 (SLTIU) is illegal.
- LUI: alu_op=ADD, rs1 forced 0, imm = {instr[31:12], 12'b0}, use_imm=1, reg_write=1.
- AUIPC: same as LUI but use_pc=1 and rs1=0.
- Illegal or unknown opcode: the entry still passes through with illegal=1, reg_write=0, alu_op=0, imm=0, use_imm=0, use_pc=0. rs1/rs2/rd are the raw instruction fields.
- rs2 is always instr[24:20], even for I/U types (harmless; use_imm selects).
- rd = x0 keeps reg_write=1; writeback suppresses it.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears at out_* after edge N.
- in_ready = !out_valid || out_ready (combinational; no skid buffer).
- Accept = in_valid && in_ready && !flush. On accept, all out_* load and out_valid=1.
- out_ready && out_valid && no accept ⇒ out_valid=0 at the next edge; data outputs hold their last value.
- Consume and accept in the same cycle ⇒ new entry loaded; out_valid stays 1 (full throughput, one per cycle).
- out_valid && !out_ready ⇒ all out_* stable; in_ready=0.
- flush=1 ⇒ out_valid=0 at the next edge regardless of other inputs. The input that cycle is discarded; in_ready follows its normal equation.
- rst=1 (takes priority over flush) ⇒ out_valid=0 and every data output 0 at the next edge. A held entry is lost.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC);
  - ALU op localparams (ALU_ADD … ALU_AND, 11-bit);
  - `decoded_t` struct holding all out_* fields except valid.
- Sub-module `instr_decoder`: purely combinational, instr+pc → `decoded_t`.
- `id_stage` wraps `instr_decoder` with the handshake register.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, all outputs 0; first accept occurs after rst drops.
- Legal decodes, one per cycle with out_ready=1:
  - add x3,x1,x2 (0x002081B3) → alu_op=0x000, rs1=1, rs2=2, rd=3, use_imm=0.
  - sub x3,x1,x2 (0x402081B3) → alu_op=0x200.
  - srai x5,x6,3 (0x40335293) → alu_op=0x205, imm=3.
  - addi x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF.
- LUI/AUIPC:
  - lui x7,0x12345 (0x123453B7) → imm=0x12345000, rs1=0, use_pc=0.
  - auipc x7,0x12345 (0x12345397) with in_pc=0x100 → use_pc=1, out_pc=0x100.
- Illegal: sltu (0x0020B1B3) and opcode 0x03 (load) → illegal=1, reg_write=0, alu_op=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable; release → back-to-back entries with no loss or duplication.
- Flush: assert flush with out_valid=1 and in_valid=1 → out_valid=0 next cycle and the flushed input never appears at the output.
